// File: rtl/uart_cmd_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_cmd_engine: host frame parser (R/W/P) between UART RX/TX and the    |
// | MU0 simulator memory; replies are sent with a strict req/ack handshake. |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module uart_cmd_engine #(
  parameter int TIMEOUT_CYCLES = 27000000,
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byteReady,
  input  logic [7:0]        dataIn,
  output logic              byteReadyOut,
  output logic [7:0]        dataOut,
  input  logic              byteSending,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              frame_err
);

  localparam int          TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  OP_R     = 8'h52;
  localparam logic [7:0]  OP_W     = 8'h57;
  localparam logic [7:0]  OP_P     = 8'h50;
  localparam logic [7:0]  OP_K     = 8'h4B;
  localparam logic [7:0]  OP_UNK   = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE, S_ARGS, S_MEM_RD, S_MEM_WAIT, S_MEM_WR, S_TX_LOAD, S_TX_ACK, S_TX_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [23:0]       arg_q, arg_d;
  logic [2:0]        arg_cnt_q, arg_cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] reply_q, reply_d;
  logic [1:0]        reply_cnt_q, reply_cnt_d;
  logic [7:0]        dout_q, dout_d;
  logic              err_q, err_d;
  logic [31:0]       arg_next;
  logic [15:0]       addr16;
  logic [15-ADDR_W:0] unused_addr_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      arg_q       <= '0;
      arg_cnt_q   <= '0;
      tmo_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      reply_q     <= '0;
      reply_cnt_q <= '0;
      dout_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      arg_q       <= arg_d;
      arg_cnt_q   <= arg_cnt_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      reply_q     <= reply_d;
      reply_cnt_q <= reply_cnt_d;
      dout_q      <= dout_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    arg_d       = arg_q;
    arg_cnt_d   = arg_cnt_q;
    tmo_d       = '0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    reply_d     = reply_q;
    reply_cnt_d = reply_cnt_q;
    dout_d      = dout_q;
    err_d       = 1'b0;
    arg_next    = {arg_q, dataIn};
    // 'W' carries address in the upper half, 'R' only has the two address bytes
    addr16      = (opcode_q == OP_W) ? arg_next[31:16] : arg_next[15:0];
    unused_addr_hi = addr16[15:ADDR_W];

    case (state_q)
      S_IDLE: begin
        if (byteReady) begin
          opcode_d  = dataIn;
          arg_d     = '0;
          arg_cnt_d = '0;
          if (dataIn == OP_R || dataIn == OP_W) begin
            state_d = S_ARGS;
          end else begin
            state_d     = S_TX_LOAD;
            reply_cnt_d = 2'd1;
            if (dataIn == OP_P) begin
              reply_d = {OP_P, {(DATA_W-8){1'b0}}};
            end else begin
              reply_d = {OP_UNK, {(DATA_W-8){1'b0}}};
              err_d   = 1'b1;
            end
          end
        end
      end
      S_ARGS: begin
        // Timeout is checked first so a coincident byte is dropped
        if (tmo_q == TMO_LAST) begin
          state_d   = S_IDLE;
          arg_d     = '0;
          arg_cnt_d = '0;
          err_d     = 1'b1;
        end else if (byteReady) begin
          arg_d     = arg_next[23:0];
          arg_cnt_d = arg_cnt_q + 3'd1;
          if (opcode_q == OP_R && arg_cnt_q == 3'd1) begin
            addr_d  = addr16[ADDR_W-1:0];
            state_d = S_MEM_RD;
          end else if (opcode_q == OP_W && arg_cnt_q == 3'd3) begin
            addr_d  = addr16[ADDR_W-1:0];
            wdata_d = arg_next[DATA_W-1:0];
            state_d = S_MEM_WR;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_MEM_RD:   state_d = S_MEM_WAIT;
      S_MEM_WAIT: begin
        reply_d     = mem_rdata;
        reply_cnt_d = 2'd2;
        state_d     = S_TX_LOAD;
      end
      S_MEM_WR: begin
        reply_d     = {OP_K, {(DATA_W-8){1'b0}}};
        reply_cnt_d = 2'd1;
        state_d     = S_TX_LOAD;
      end
      S_TX_LOAD: begin
        dout_d      = reply_q[DATA_W-1 -: 8];
        reply_d     = reply_q << 8;
        reply_cnt_d = reply_cnt_q - 2'd1;
        state_d     = S_TX_ACK;
      end
      S_TX_ACK: begin
        if (byteSending) state_d = S_TX_DONE;
      end
      S_TX_DONE: begin
        if (!byteSending) state_d = (reply_cnt_q != 2'd0) ? S_TX_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (byteReady && state_q != S_IDLE && state_q != S_ARGS) err_d = 1'b1;
  end

  // Request is gated by byteSending so it drops the instant TX acknowledges
  assign byteReadyOut = (state_q == S_TX_ACK) && !byteSending;
  assign dataOut      = dout_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_we       = (state_q == S_MEM_WR);
  assign mem_re       = (state_q == S_MEM_RD);
  assign frame_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_engine.sv
`default_nettype none
// Bench for uart_cmd_engine: directed frames push expectations into queues,
// a negedge monitor emulates TX/memory and pops/compares every DUT output event.
module tb_uart_cmd_engine;

  localparam int TMO = 40;

  typedef struct { logic [7:0] b; int lat; } tx_exp_t;
  typedef struct { bit wr; logic [11:0] addr; logic [15:0] wdata; int lat; } mem_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byteReady = 1'b0;
  logic [7:0]  dataIn = 8'h00;
  logic        byteSending = 1'b0;
  logic        byteReadyOut;
  logic [7:0]  dataOut;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re, frame_err;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] mem [0:4095];

  tx_exp_t  tx_q[$];
  mem_exp_t mem_q[$];
  tx_exp_t  t;
  mem_exp_t m;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_byte_cyc = 0;
  int err_pushed = 0;
  int err_seen = 0;
  int busy = 0;
  bit tx_hold = 1'b0;

  uart_cmd_engine #(.TIMEOUT_CYCLES(TMO), .ADDR_W(12), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .byteReady(byteReady), .dataIn(dataIn),
    .byteReadyOut(byteReadyOut), .dataOut(dataOut), .byteSending(byteSending),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Monitor: TX emulation, memory strobes and frame_err
  always @(negedge clk) begin
    if (byteSending) begin
      compared++;
      if (byteReadyOut !== 1'b0) begin
        mismatched++;
        $display("FAIL req_during_busy: byteReadyOut=%b required 0", byteReadyOut);
      end
      if (busy > 0) busy--;
      else byteSending = 1'b0;
    end else if (byteReadyOut === 1'b1 && !tx_hold) begin
      compared++;
      if (tx_q.size() == 0) begin
        mismatched++;
        $display("FAIL tx_unexpected: got %02h, required no byte", dataOut);
      end else begin
        t = tx_q.pop_front();
        if (dataOut !== t.b || (t.lat >= 0 && cyc - last_byte_cyc != t.lat)) begin
          mismatched++;
          $display("FAIL tx_byte: got %02h lat %0d, required %02h lat %0d",
                   dataOut, cyc - last_byte_cyc, t.b, t.lat);
        end
      end
      byteSending = 1'b1;
      busy = 3;
    end

    if (mem_we === 1'b1 || mem_re === 1'b1) begin
      compared++;
      if (mem_q.size() == 0) begin
        mismatched++;
        $display("FAIL mem_unexpected: we=%b re=%b addr=%03h, required no access",
                 mem_we, mem_re, mem_addr);
      end else begin
        m = mem_q.pop_front();
        if (mem_we !== m.wr || mem_re !== !m.wr || mem_addr !== m.addr ||
            (m.wr && mem_wdata !== m.wdata) || (cyc - last_byte_cyc != m.lat)) begin
          mismatched++;
          $display("FAIL mem_access: we=%b re=%b addr=%03h wdata=%04h lat=%0d, required wr=%b addr=%03h wdata=%04h lat=%0d",
                   mem_we, mem_re, mem_addr, mem_wdata, cyc - last_byte_cyc, m.wr, m.addr, m.wdata, m.lat);
        end
      end
    end

    if (frame_err === 1'b1) begin
      compared++;
      err_seen++;
      if (err_seen > err_pushed) begin
        mismatched++;
        $display("FAIL frame_err_unexpected: got pulse, required none (seen %0d expected %0d)",
                 err_seen, err_pushed);
      end
    end
  end

  task automatic push_tx(input logic [7:0] b, input int lat);
    tx_exp_t e;
    e.b = b;
    e.lat = lat;
    tx_q.push_back(e);
  endtask

  task automatic push_mem(input bit wr, input logic [11:0] a, input logic [15:0] d);
    mem_exp_t e;
    e.wr = wr;
    e.addr = a;
    e.wdata = d;
    e.lat = 1;
    mem_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    byteReady = 1'b1;
    dataIn = b;
    last_byte_cyc = cyc;
    @(posedge clk); #1;
    byteReady = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((tx_q.size() != 0 || mem_q.size() != 0 || err_seen < err_pushed || byteSending) && n < 600) begin
      @(posedge clk);
      n++;
    end
    if (n >= 600) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: pending tx=%0d mem=%0d err=%0d, required all 0",
               name, tx_q.size(), mem_q.size(), err_pushed - err_seen);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    compared++;
    if (byteReadyOut !== 1'b0 || dataOut !== 8'h00 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
        mem_addr !== 12'h000 || mem_wdata !== 16'h0000 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL %s: req=%b dout=%02h we=%b re=%b addr=%03h wdata=%04h err=%b, required all 0",
               name, byteReadyOut, dataOut, mem_we, mem_re, mem_addr, mem_wdata, frame_err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal end");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_state");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Writes then readback
    push_mem(1'b1, 12'h02A, 16'h1234); push_tx(8'h4B, -1);
    send_frame('{8'h57, 8'h00, 8'h2A, 8'h12, 8'h34});
    drain("write_02a");
    push_mem(1'b1, 12'h123, 16'hBEEF); push_tx(8'h4B, -1);
    send_frame('{8'h57, 8'h01, 8'h23, 8'hBE, 8'hEF});
    drain("write_123");
    push_mem(1'b0, 12'h02A, 16'h0000); push_tx(8'h12, -1); push_tx(8'h34, -1);
    send_frame('{8'h52, 8'h00, 8'h2A});
    drain("read_02a");
    push_mem(1'b0, 12'h123, 16'h0000); push_tx(8'hBE, -1); push_tx(8'hEF, -1);
    send_frame('{8'h52, 8'hF1, 8'h23});
    drain("read_f123");

    // Unknown opcode and ping
    err_pushed++; push_tx(8'h3F, -1);
    send_frame('{8'h41});
    drain("unknown_op");
    push_tx(8'h50, 2);
    send_frame('{8'h50});
    drain("ping");

    // Timeout inside a partial write, then normal ping
    err_pushed++;
    send_frame('{8'h57, 8'h00, 8'h01});
    drain("timeout_w");
    push_tx(8'h50, 2);
    send_frame('{8'h50});
    drain("ping_after_timeout");

    // Byte arriving in the very cycle the timeout fires is dropped
    err_pushed++;
    send_byte(8'h52);
    repeat (TMO - 2) @(posedge clk);
    send_byte(8'h50);
    drain("timeout_vs_byte");

    // Byte injected during reply
    push_mem(1'b0, 12'h02A, 16'h0000); push_tx(8'h12, -1); push_tx(8'h34, -1);
    send_frame('{8'h52, 8'h00, 8'h2A});
    n = 0;
    while (!byteSending && n < 50) begin @(negedge clk); n++; end
    err_pushed++;
    send_byte(8'h55);
    drain("inject_during_reply");

    // Async reset while a reply request is held
    tx_hold = 1'b1;
    send_byte(8'h50);
    n = 0;
    while (byteReadyOut !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    compared++;
    if (byteReadyOut !== 1'b1) begin
      mismatched++;
      $display("FAIL hold_request: byteReadyOut=%b, required 1", byteReadyOut);
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1 check_reset_outputs("async_reset_mid_reply");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tx_hold = 1'b0;
    repeat (5) @(posedge clk);
    push_tx(8'h50, 2);
    send_frame('{8'h50});
    drain("ping_after_reset");

    compared++;
    if (tx_q.size() != 0 || mem_q.size() != 0 || err_seen != err_pushed) begin
      mismatched++;
      $display("FAIL final_queues: tx=%0d mem=%0d err_seen=%0d, required 0 0 %0d",
               tx_q.size(), mem_q.size(), err_seen, err_pushed);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
